fifo_control: RTL
=================

// Module: fifo_control
// PURPOSE
//   Control unit for the 16-entry FIFO datapath. Arbitrates push/pop requests from
//   the FIFO user and drives the datapath control inputs: pointer inc/clear, address
//   select, RAM chip select and write enable. Takes back the datapath's pointer-equality
//   flag 'test' and derives full/empty from it, one memory access per operation.
// PARAMETERS
//   PUSH_PRIORITY  1  1: push wins when push and pop are both eligible in IDLE; 0: pop wins
//   RD_LATENCY     1  cycles from the READ state to valid datapath data_out (1 or 2)
// PORTS
//   ck            in   1  clock, rising edge
//   reset         in   1  asynchronous, active-high
//   push          in   1  write request (level); data_in is held stable by the user until push_ack
//   pop           in   1  read request (level); held until pop_ack
//   flush         in   1  empty the FIFO (level, sampled in IDLE only)
//   test          in   1  from datapath: 1 when write pointer == read pointer
//   inc_wp        out  1  to datapath: advance write pointer
//   inc_rp        out  1  to datapath: advance read pointer
//   clear_wp      out  1  to datapath: synchronous clear of write pointer
//   clear_rp      out  1  to datapath: synchronous clear of read pointer
//   wp_rp_sel     out  1  to datapath: 1 = address from write pointer, 0 = from read pointer
//   chip_sel      out  1  to datapath RAM: access enable
//   write_enable  out  1  to datapath RAM: 1 = write, 0 = read
//   push_ack      out  1  write performed this cycle
//   pop_ack       out  1  read issued this cycle
//   rd_valid      out  1  datapath data_out holds the popped byte this cycle
//   full          out  1  16 entries stored
//   empty         out  1  0 entries stored
//   busy          out  1  state != IDLE
// BEHAVIOUR
//   - Moore FSM, states IDLE, WRITE, READ, FLUSH. Every output except full/empty is decoded
//     from the state register only.
//   - Occupancy flag last_wr: set on WRITE, cleared on READ and FLUSH.
//     full = test & last_wr; empty = test & ~last_wr (combinational).
//   - IDLE: all datapath controls 0, wp_rp_sel = 0. Next state, in priority order:
//     flush -> FLUSH; push&~full and pop&~empty both -> WRITE if PUSH_PRIORITY else READ;
//     push&~full -> WRITE; pop&~empty -> READ; otherwise stay in IDLE.
//   - WRITE (1 cycle): chip_sel=1, write_enable=1, wp_rp_sel=1, inc_wp=1, push_ack=1 -> IDLE.
//   - READ (1 cycle): chip_sel=1, write_enable=0, wp_rp_sel=0, inc_rp=1, pop_ack=1 -> IDLE.
//     rd_valid pulses RD_LATENCY cycles after the READ cycle, through a shift register.
//   - FLUSH (1 cycle): clear_wp=1, clear_rp=1, last_wr cleared -> IDLE. An rd_valid already
//     in flight is still delivered.
//   - Throughput: at most one operation per 2 cycles. Returning to IDLE between operations
//     lets 'test' settle after each pointer update. Full/empty decisions use the
//     post-update 'test' only.
//   - Push while full, or pop while empty: no ack; the request stays pending and the FSM
//     stays in IDLE until the flag clears.
//   - Pointer wrap 15->0 is handled by the datapath; the 'test'+last_wr scheme covers the
//     wrap without any pointer values.
//   - Reset (asynchronous, any state, mid-operation included): state=IDLE, last_wr=0,
//     rd_valid pipeline=0. All control outputs, acks, rd_valid and busy go to 0 immediately.
//     With the datapath also in reset, test=1, so empty=1 and full=0.
// TESTING
//   1. Reset, then idle -> empty=1, full=0, busy=0, all datapath controls 0.
//   2. Push 0xA5 then pop -> push_ack 1 cycle with inc_wp=chip_sel=write_enable=wp_rp_sel=1;
//      pop_ack, then rd_valid RD_LATENCY cycles later with data_out=0xA5; empty=1 again.
//   3. Push 16 bytes 0x00..0x0F -> full=1 after the 16th ack; 17th push never acked.
//      Then 16 pops return 0x00..0x0F in order (pointer wrap exercised); empty=1.
//   4. push and pop held together with 8 entries stored -> ops follow PUSH_PRIORITY and
//      alternate through IDLE; occupancy is unchanged after an equal number of acks.
//   5. 5 entries stored, flush=1 -> one FLUSH cycle with clear_wp=clear_rp=1; then
//      empty=1 and a pop is not acked.
//   6. Reset asserted during WRITE -> push_ack/inc_wp drop without waiting for ck;
//      state IDLE, empty=1 after release.

Source files
------------

// File: rtl/fifo_control_if.sv
// Handshake and datapath-control bundle for the 16-entry FIFO controller.
// master = FIFO user plus datapath, slave = the controller itself.
interface fifo_control_if;
  logic push;
  logic pop;
  logic flush;
  logic test;
  logic inc_wp;
  logic inc_rp;
  logic clear_wp;
  logic clear_rp;
  logic wp_rp_sel;
  logic chip_sel;
  logic write_enable;
  logic push_ack;
  logic pop_ack;
  logic rd_valid;
  logic full;
  logic empty;
  logic busy;

  modport master (
    output push, pop, flush, test,
    input  inc_wp, inc_rp, clear_wp, clear_rp,
    input  wp_rp_sel, chip_sel, write_enable,
    input  push_ack, pop_ack, rd_valid,
    input  full, empty, busy
  );

  modport slave (
    input  push, pop, flush, test,
    output inc_wp, inc_rp, clear_wp, clear_rp,
    output wp_rp_sel, chip_sel, write_enable,
    output push_ack, pop_ack, rd_valid,
    output full, empty, busy
  );
endinterface

// File: rtl/fifo_control.sv
// Moore controller for the 16-entry FIFO datapath.
// One memory access per operation, always separated by an IDLE cycle.
module fifo_control #(
  parameter bit PUSH_PRIORITY = 1'b1,
  parameter int RD_LATENCY    = 1
) (
  input logic        ck,
  input logic        reset,
  fifo_control_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;
  logic   last_wr;
  logic   [RD_LATENCY-1:0] rd_pipe;

  logic want_wr;
  logic want_rd;
  logic go_wr;
  logic go_rd;

  // pointer equality is ambiguous; last_wr says which way it resolved
  assign bus.full  = bus.test & last_wr;
  assign bus.empty = bus.test & ~last_wr;

  assign want_wr = bus.push & ~bus.full;
  assign want_rd = bus.pop & ~bus.empty;
  assign go_wr   = want_wr & (~want_rd | PUSH_PRIORITY);
  assign go_rd   = want_rd & ~go_wr;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) begin
      priority case (1'b1)
        bus.flush: state_nx = FLUSH;
        go_wr:     state_nx = WRITE;
        go_rd:     state_nx = READ;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.inc_wp       = 1'b0;
    bus.inc_rp       = 1'b0;
    bus.clear_wp     = 1'b0;
    bus.clear_rp     = 1'b0;
    bus.wp_rp_sel    = 1'b0;
    bus.chip_sel     = 1'b0;
    bus.write_enable = 1'b0;
    bus.push_ack     = 1'b0;
    bus.pop_ack      = 1'b0;
    bus.busy         = (state != IDLE);
    unique case (state)
      WRITE: begin
        bus.chip_sel     = 1'b1;
        bus.write_enable = 1'b1;
        bus.wp_rp_sel    = 1'b1;
        bus.inc_wp       = 1'b1;
        bus.push_ack     = 1'b1;
      end
      READ: begin
        bus.chip_sel = 1'b1;
        bus.inc_rp   = 1'b1;
        bus.pop_ack  = 1'b1;
      end
      FLUSH: begin
        bus.clear_wp = 1'b1;
        bus.clear_rp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      last_wr <= 1'b0;
    end else if (state == WRITE) begin
      last_wr <= 1'b1;
    end else if (state == READ || state == FLUSH) begin
      last_wr <= 1'b0;
    end
  end

  // flush leaves in-flight read data alone
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= (state == READ);
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign bus.rd_valid = rd_pipe[RD_LATENCY-1];

endmodule
